// File: rtl/data_ram_resp_pkg.sv
// Shared encodings for the MEM-stage data-memory responder.
package data_ram_resp_pkg;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam int   DRAM_ADDR_W  = 10;

  typedef enum logic [1:0] {
    DRAM_IDLE,
    DRAM_WAIT,
    DRAM_RESP
  } dram_state_e;

endpackage

// File: rtl/data_ram_resp_array.sv
// Word storage built from four byte lanes; lane l holds bits [8l+7:8l].
// Synchronous lane-masked write and registered read.
module data_ram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_sel,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_we && i_sel[l]) mem[i_addr] <= i_wdata[8*l +: 8];
      if (i_re)             o_rdata[8*l +: 8] <= mem[i_addr];
    end
  end

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: accepts one MEM-stage request, waits LATENCY cycles,
// performs the access on the edge into RESP and acks for one cycle.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W  = DRAM_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_stallreq
);

  localparam logic [2:0] CNT_INIT = 3'((LATENCY > 0) ? LATENCY - 1 : 0);

  dram_state_e state, state_nxt;
  logic [2:0]  cnt;
  logic        in_range, commit, wr_en, rd_en, rd_ok;
  logic [31:0] arr_rdata;

  assign in_range = ~|i_addr[31:ADDR_W+2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= DRAM_IDLE;
    else          state <= state_nxt;
  end

  // Dropping i_ce while waiting is a pipeline flush: abandon without access.
  always_comb begin
    state_nxt = state;
    case (state)
      DRAM_IDLE: if (i_ce == CHIP_ENABLE) state_nxt = (LATENCY > 0) ? DRAM_WAIT : DRAM_RESP;
      DRAM_WAIT: begin
        if (i_ce == CHIP_DISABLE) state_nxt = DRAM_IDLE;
        else if (cnt == 3'd0)     state_nxt = DRAM_RESP;
      end
      DRAM_RESP: state_nxt = DRAM_IDLE;
      default:   state_nxt = DRAM_IDLE;
    endcase
  end

  always_comb begin
    o_ack      = (state == DRAM_RESP);
    o_stallreq = (i_ce == CHIP_ENABLE && state != DRAM_RESP) ? STOP : NO_STOP;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                   cnt <= 3'd0;
    else if (state == DRAM_IDLE && i_ce)            cnt <= CNT_INIT;
    else if (state == DRAM_WAIT && cnt != 3'd0)     cnt <= cnt - 3'd1;
  end

  // Request fields are sampled here, on the edge that enters RESP.
  assign commit = (i_ce == CHIP_ENABLE) &&
                  ((state == DRAM_IDLE && LATENCY == 0) ||
                   (state == DRAM_WAIT && cnt == 3'd0));
  assign wr_en  = commit &&  i_we && in_range;
  assign rd_en  = commit && !i_we && in_range;

  // Stores and out-of-range loads present zero; memory output is unreset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    rd_ok <= 1'b0;
    else if (commit) rd_ok <= rd_en;
  end

  assign o_rdata = rd_ok ? arr_rdata : 32'h0;

  data_ram_array #(.ADDR_W(ADDR_W)) u_array (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_re    (rd_en),
    .i_addr  (i_addr[ADDR_W+1:2]),
    .i_sel   (i_sel),
    .i_wdata (i_wdata),
    .o_rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench: dut 0 runs LATENCY=2, dut 1 runs LATENCY=0.
module tb_data_ram_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce    [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [3:0]  sel   [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        stall [2];

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_ram_resp #(.ADDR_W(10), .LATENCY(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce[0]), .i_we(we[0]), .i_addr(addr[0]),
    .i_sel(sel[0]), .i_wdata(wdata[0]), .o_rdata(rdata[0]), .o_ack(ack[0]),
    .o_stallreq(stall[0]));

  data_ram_resp #(.ADDR_W(10), .LATENCY(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce[1]), .i_we(we[1]), .i_addr(addr[1]),
    .i_sel(sel[1]), .i_wdata(wdata[1]), .o_rdata(rdata[1]), .o_ack(ack[1]),
    .o_stallreq(stall[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected read value.
  always @(negedge clk) begin
    if (rst_n && ack[0]) begin
      if (q0.size() == 0) chk("dut0_unexpected_ack", 32'd1, 32'd0);
      else chk("dut0_rdata", rdata[0], q0.pop_front());
    end
    if (rst_n && ack[1]) begin
      if (q1.size() == 0) chk("dut1_unexpected_ack", 32'd1, 32'd0);
      else chk("dut1_rdata", rdata[1], q1.pop_front());
    end
  end

  // Issue one request; count stall cycles before the ack and check its timing.
  task automatic req(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] wd, input logic [31:0] exp, input int exp_stall,
                     input bit keep);
    int n = 0;
    int stall_n = 0;
    bit got = 0;
    @(posedge clk); #1;
    ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = wd;
    if (d == 0) q0.push_back(exp); else q1.push_back(exp);
    while (n < 20) begin
      @(negedge clk);
      if (ack[d]) begin got = 1; break; end
      if (stall[d]) stall_n++;
      n++;
    end
    if (!got) chk($sformatf("dut%0d_ack_timeout", d), 32'd0, 32'd1);
    else begin
      chk($sformatf("dut%0d_stall_cycles", d), stall_n, exp_stall);
      chk($sformatf("dut%0d_ack_cycle", d), n, exp_stall);
      chk($sformatf("dut%0d_stall_in_resp", d), {31'd0, stall[d]}, 32'd0);
    end
    if (!keep) begin
      @(posedge clk); #1;
      ce[d] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      ce[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; sel[i] = '0; wdata[i] = '0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_rdata", rdata[i], 32'h0);
      chk("reset_ack", {31'd0, ack[i]}, 32'd0);
      chk("reset_stall", {31'd0, stall[i]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Store/load, lane merge, no-op store, ignored low address bits
    req(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 3, 0);
    req(0, 0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 3, 0);
    req(0, 1, 32'h10, 4'b0100, 32'h00AA0000, 32'h0, 3, 0);
    req(0, 0, 32'h10, 4'hF, 32'h0, 32'hDEAABEEF, 3, 0);
    req(0, 1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0, 3, 0);
    req(0, 0, 32'h13, 4'hF, 32'h0, 32'hDEAABEEF, 3, 0);

    // Out-of-range store must not alias onto word 0
    req(0, 1, 32'h0, 4'hF, 32'h0BADC0DE, 32'h0, 3, 0);
    req(0, 1, 32'h00100000, 4'hF, 32'h11111111, 32'h0, 3, 0);
    req(0, 0, 32'h00100000, 4'hF, 32'h0, 32'h0, 3, 0);
    req(0, 0, 32'h0, 4'hF, 32'h0, 32'h0BADC0DE, 3, 0);

    // Flush abort during WAIT
    req(0, 1, 32'h20, 4'hF, 32'hCAFEF00D, 32'h0, 3, 0);
    @(posedge clk); #1;
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; sel[0] = 4'hF; wdata[0] = 32'h12345678;
    @(negedge clk);
    chk("abort_stall_accept", {31'd0, stall[0]}, 32'd1);
    @(posedge clk); #1;
    ce[0] = 1'b0;
    #1 chk("abort_stall_drop", {31'd0, stall[0]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ack", {31'd0, ack[0]}, 32'd0);
    end
    req(0, 0, 32'h20, 4'hF, 32'h0, 32'hCAFEF00D, 3, 0);

    // Reset mid-WAIT during a store to 0x10
    @(posedge clk); #1;
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; sel[0] = 4'hF; wdata[0] = 32'h55555555;
    @(posedge clk); #1;
    rst_n = 1'b0; ce[0] = 1'b0;
    #1;
    chk("midrst_rdata", rdata[0], 32'h0);
    chk("midrst_ack", {31'd0, ack[0]}, 32'd0);
    chk("midrst_stall", {31'd0, stall[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req(0, 0, 32'h10, 4'hF, 32'h0, 32'hDEAABEEF, 3, 0);

    // LATENCY=0 back-to-back: stores then loads with i_ce held high
    for (int i = 0; i < 4; i++)
      req(1, 1, 32'h40 + 32'(4*i), 4'hF, 32'hA5000000 + 32'(i), 32'h0, 1, 1);
    for (int i = 0; i < 4; i++)
      req(1, 0, 32'h40 + 32'(4*i), 4'hF, 32'h0, 32'hA5000000 + 32'(i), 1, i != 3);

    repeat (4) @(negedge clk);
    chk("dut0_pending", 32'(q0.size()), 32'd0);
    chk("dut1_pending", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
